// File: rtl/rr_job_ctrl.sv
// Round-robin job controller: grants one of NUM_CH requesters, supervises the worker with a timeout and bounded retries.
// Latency: start seen in IDLE -> issue pulse next cycle; done seen in RUN -> complete next cycle, IDLE the cycle after.
// Backpressure: start is level-held by requesters and only arbitrated in IDLE; HOLD stalls all new grants until init.
module rr_job_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  start,
    input  logic               done,
    input  logic               init,
    output logic [NUM_CH-1:0]  grant,
    output logic [CH_W-1:0]    ch_id,
    output logic               issue,
    output logic               complete,
    output logic               ack,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         out
);

    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_RETRY = 3'd4;

    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [NUM_CH-1:0]  ONEHOT0   = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [2:0]         r_state;
    logic [NUM_CH-1:0]  r_grant;
    logic [CH_W-1:0]    r_ch_id;
    logic [CH_W-1:0]    r_last;
    logic [RETRY_W-1:0] r_retry;
    logic [TMR_W-1:0]   r_timer;

    logic               w_req_vld;
    logic [CH_W-1:0]    w_winner;
    logic [CH_W-1:0]    w_idx;
    int                 w_pos;
    logic               w_legal;
    logic               w_retry_left;

    // Round-robin search: first requester after the last winner, wrapping modulo NUM_CH.
    always_comb begin
        w_req_vld = 1'b0;
        w_winner  = '0;
        w_idx     = '0;
        w_pos     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_pos = (int'(r_last) + i) % NUM_CH;
            w_idx = CH_W'(w_pos);
            if (!w_req_vld && start[w_idx]) begin
                w_req_vld = 1'b1;
                w_winner  = w_idx;
            end
        end
    end

    assign w_retry_left = (int'(r_retry) < MAX_RETRY);

    // Controller state, grant ownership, attempt timer and retry count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ch_id <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
            r_retry <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_vld) begin
                        r_state <= S_RUN;
                        r_grant <= ONEHOT0 << w_winner;
                        r_ch_id <= w_winner;
                        r_last  <= w_winner;
                        r_retry <= '0;
                        r_timer <= '0;
                    end
                end
                S_RUN: begin
                    // done takes priority over an expiring timer in the same cycle
                    if (done) begin
                        r_state <= S_DONE;
                    end else if (r_timer == TMR_LAST) begin
                        if (w_retry_left) begin
                            r_state <= S_RETRY;
                            r_retry <= r_retry + RETRY_W'(1);
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
                S_HOLD: begin
                    if (init) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                    end
                end
                S_RETRY: begin
                    r_state <= S_RUN;
                    r_timer <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from registers; illegal codes look like IDLE.
    assign w_legal   = (r_state <= S_RETRY);
    assign grant     = w_legal ? r_grant : '0;
    assign ch_id     = r_ch_id;
    assign issue     = (r_state == S_RUN) && (r_timer == '0);
    assign complete  = (r_state == S_DONE);
    assign ack       = (r_state == S_HOLD);
    assign retry_cnt = r_retry;
    assign out       = w_legal ? r_state : S_IDLE;

endmodule
